// File: rtl/fp_pkg.sv
// fp_pkg: shared types, constants and special-operand classification for the FP datapath
package fp_pkg;
  typedef enum logic [2:0] {RNE = 3'd0, RTZ = 3'd1, RUP = 3'd2, RDN = 3'd3, RNA = 3'd4, RAW = 3'd5} rnd_t;
  typedef enum logic [1:0] {IDLE, ITER, ROUND, DONE} state_t;
  typedef struct packed {
    logic hit;
    logic [31:0] z;
    logic [7:0] st;
  } spec_t;
  localparam int ST_ZERO = 0;
  localparam int ST_INF = 1;
  localparam int ST_NAN = 2;
  localparam int ST_TINY = 3;
  localparam int ST_HUGE = 4;
  localparam int ST_INEXACT = 5;
  localparam int ST_DBZ = 6;
  localparam int BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] INF = 32'h7F800000;
  localparam logic [31:0] MAX_NORM = 32'h7F7FFFFF;
  function automatic logic is_special(input logic [31:0] a, input logic [31:0] b);
    return (&a[30:23]) || (&b[30:23]) || (a[30:23] == 8'd0) || (b[30:23] == 8'd0);
  endfunction
  function automatic spec_t classify(input logic [31:0] a, input logic [31:0] b);
    logic an, bn, ai, bi, az, bz, sg;
    spec_t r;
    an = (&a[30:23]) && (|a[22:0]);
    bn = (&b[30:23]) && (|b[22:0]);
    ai = (&a[30:23]) && !(|a[22:0]);
    bi = (&b[30:23]) && !(|b[22:0]);
    az = a[30:23] == 8'd0;
    bz = b[30:23] == 8'd0;
    sg = a[31] ^ b[31];
    r.hit = is_special(a, b);
    r.z = {sg, 31'd0};
    r.st = '0;
    if (an || bn || (az && bz) || (ai && bi)) begin
      r.z = QNAN;
      r.st[ST_NAN] = 1'b1;
    end else if (bz) begin
      r.z = {sg, INF[30:0]};
      r.st[ST_INF] = 1'b1;
      r.st[ST_DBZ] = 1'b1;
    end else if (ai) begin
      r.z = {sg, INF[30:0]};
      r.st[ST_INF] = 1'b1;
    end else begin
      r.st[ST_ZERO] = 1'b1;
    end
    return r;
  endfunction
endpackage

// File: rtl/mant_div_seq.sv
// mant_div_seq: restoring mantissa divider producing one quotient bit per step
module mant_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [23:0] ma,
  input  logic [23:0] mb,
  output logic [25:0] q,
  output logic        sticky
);
  logic [24:0] rem;
  logic [23:0] d;
  logic        ge;
  logic [24:0] diff;
  assign ge = rem >= {1'b0, d};
  assign diff = rem - {1'b0, d};
  assign sticky = rem != 25'd0;
  // pre-normalise the dividend so the quotient lands in [1,2), then shift in one bit per step
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rem <= '0;
      d <= '0;
      q <= '0;
    end else if (load) begin
      rem <= (ma < mb) ? {ma, 1'b0} : {1'b0, ma};
      d <= mb;
      q <= '0;
    end else if (step) begin
      q <= {q[24:0], ge};
      rem <= (ge ? diff : rem) << 1;
    end
endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential single-precision divider; FP_DIV_EARLY_EXIT_EN enables the special-operand fast path
module fp_div_seq
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  rnd,
  output logic        busy,
  output logic        done,
  output logic [31:0] z,
  output logic [7:0]  status
);
  state_t state, nxt;
  logic [31:0] ra, rb;
  rnd_t mode;
  logic signed [9:0] e, er;
  logic [4:0] cnt;
  logic [25:0] q;
  logic sticky, load, step, fast, lt_in;
  logic [23:0] ma_in, mb_in, m;
  logic g, r, x, sg, away, toinf, inc;
  logic [24:0] mr;
  logic [31:0] res_z;
  logic [7:0] res_st;
  spec_t sp_r;
  assign ma_in = {1'b1, a[22:0]};
  assign mb_in = {1'b1, b[22:0]};
  assign lt_in = ma_in < mb_in;
  assign load = state == IDLE && start;
  assign step = state == ITER;
  assign sp_r = classify(ra, rb);
`ifdef FP_DIV_EARLY_EXIT_EN
  assign fast = is_special(a, b);
`else
  assign fast = 1'b0;
`endif
  mant_div_seq u_mant (
    .clk(clk),
    .rst(rst),
    .load(load),
    .step(step),
    .ma(ma_in),
    .mb(mb_in),
    .q(q),
    .sticky(sticky)
  );
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= nxt;
  // next-state and handshake outputs
  always_comb begin
    nxt = state;
    busy = state == ITER || state == ROUND;
    done = state == DONE;
    case (state)
      IDLE: nxt = start ? (fast ? ROUND : ITER) : IDLE;
      ITER: nxt = cnt == 5'd25 ? ROUND : ITER;
      ROUND: nxt = DONE;
      default: nxt = IDLE;
    endcase
  end
  // operand capture, iteration count and result registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      ra <= '0;
      rb <= '0;
      mode <= RNE;
      e <= '0;
      cnt <= '0;
      z <= '0;
      status <= '0;
    end else begin
      if (load) begin
        ra <= a;
        rb <= b;
        mode <= rnd > 3'd5 ? RNE : rnd_t'(rnd);
        e <= $signed({2'b0, a[30:23]}) - $signed({2'b0, b[30:23]}) + $signed(10'(BIAS)) - $signed({9'b0, lt_in});
        cnt <= '0;
      end
      if (step) cnt <= cnt + 5'd1;
      if (state == ROUND) begin
        z <= res_z;
        status <= res_st;
      end
    end
  // rounding, overflow/underflow clamping and special-case override
  always_comb begin
    m = q[25:2];
    g = q[1];
    r = q[0];
    x = g | r | sticky;
    sg = ra[31] ^ rb[31];
    away = mode == RAW || (mode == RUP && !sg) || (mode == RDN && sg);
    toinf = away || mode == RNE || mode == RNA;
    inc = mode == RNE ? g & (r | sticky | m[0]) : mode == RNA ? g : away & x;
    mr = {1'b0, m} + {24'd0, inc};
    er = e + $signed({9'b0, mr[24]});
    res_z = {sg, er[7:0], mr[24] ? mr[23:1] : mr[22:0]};
    res_st = '0;
    if (er >= 10'sd255) begin
      res_z = toinf ? {sg, INF[30:0]} : {sg, MAX_NORM[30:0]};
      res_st[ST_HUGE] = 1'b1;
      res_st[ST_INEXACT] = 1'b1;
      res_st[ST_INF] = toinf;
    end else if (er <= 10'sd0) begin
      res_z = {sg, away ? 8'd1 : 8'd0, 23'd0};
      res_st[ST_TINY] = 1'b1;
      res_st[ST_INEXACT] = 1'b1;
      res_st[ST_ZERO] = !away;
    end else begin
      res_st[ST_INEXACT] = x;
    end
    if (sp_r.hit) begin
      res_z = sp_r.z;
      res_st = sp_r.st;
    end
  end
endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: randomized self-checking bench with an integer-arithmetic reference model
module tb_fp_div_seq;
  typedef struct packed {
    logic [31:0] z;
    logic [7:0] st;
    logic sp;
  } res_t;
  typedef struct packed {
    logic [31:0] z;
    logic [7:0] st;
    logic [31:0] lat;
    logic [31:0] acc;
  } ent_t;
`ifdef FP_DIV_EARLY_EXIT_EN
  localparam int LAT_SP = 2;
`else
  localparam int LAT_SP = 28;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [2:0] rnd = '0;
  logic busy, done;
  logic [31:0] z;
  logic [7:0] status;
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  ent_t sb[$];
  fp_div_seq dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .a(a),
    .b(b),
    .rnd(rnd),
    .busy(busy),
    .done(done),
    .z(z),
    .status(status)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  function automatic res_t model(input logic [31:0] x, input logic [31:0] y, input logic [2:0] rm);
    res_t o;
    int ex, ey, e, md, k;
    bit xn, yn, xi, yi, xz, yz, sg, exact, tie, above, up, toinf, away;
    longint unsigned mx, my, n, rem, lower, half, mant;
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xn = ex == 255 && x[22:0] != 0;
    yn = ey == 255 && y[22:0] != 0;
    xi = ex == 255 && x[22:0] == 0;
    yi = ey == 255 && y[22:0] == 0;
    xz = ex == 0;
    yz = ey == 0;
    sg = x[31] ^ y[31];
    md = rm > 3'd5 ? 0 : int'(rm);
    o.sp = 1'b1;
    if (xn || yn || (xz && yz) || (xi && yi)) begin
      o.z = 32'h7FC00000; o.st = 8'h04; return o;
    end
    if (yz) begin
      o.z = {sg, 8'hFF, 23'd0}; o.st = 8'h42; return o;
    end
    if (xi) begin
      o.z = {sg, 8'hFF, 23'd0}; o.st = 8'h02; return o;
    end
    if (xz || yi) begin
      o.z = {sg, 31'd0}; o.st = 8'h01; return o;
    end
    o.sp = 1'b0;
    mx = 64'h800000 | 64'(x[22:0]);
    my = 64'h800000 | 64'(y[22:0]);
    n = (mx << 40) / my;
    rem = (mx << 40) % my;
    e = ex - ey + 127;
    if (n >= (64'd1 << 40)) k = 17;
    else begin
      k = 16;
      e--;
    end
    mant = n >> k;
    lower = n & ((64'd1 << k) - 1);
    half = 64'd1 << (k - 1);
    exact = lower == 0 && rem == 0;
    tie = lower == half && rem == 0;
    above = lower > half || (lower == half && rem != 0);
    away = md == 5 || (md == 2 && !sg) || (md == 3 && sg);
    toinf = away || md == 0 || md == 4;
    up = md == 0 ? (above || (tie && mant[0])) : md == 4 ? (above || tie) : (away && !exact);
    mant += 64'(up);
    if (mant == (64'd1 << 24)) begin
      mant = 64'd1 << 23;
      e++;
    end
    if (e >= 255) begin
      o.z = toinf ? {sg, 8'hFF, 23'd0} : {sg, 8'hFE, 23'h7FFFFF};
      o.st = toinf ? 8'h32 : 8'h30;
    end else if (e <= 0) begin
      o.z = away ? {sg, 8'h01, 23'd0} : {sg, 31'd0};
      o.st = away ? 8'h28 : 8'h29;
    end else begin
      o.z = {sg, 8'(e), mant[22:0]};
      o.st = exact ? 8'h00 : 8'h20;
    end
    return o;
  endfunction
  task automatic pin(input string nm, input logic [31:0] x, input logic [31:0] y, input logic [2:0] r, input logic [39:0] exp);
    res_t m;
    m = model(x, y, r);
    chk(nm, {m.z, m.st}, exp);
  endtask
  task automatic issue(input logic [31:0] ta, input logic [31:0] tb, input logic [2:0] tr);
    res_t m;
    int t;
    t = 0;
    while ((busy || done) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (busy || done) chk("issue_wait_idle", {38'd0, busy, done}, 40'd0);
    m = model(ta, tb, tr);
    a = ta;
    b = tb;
    rnd = tr;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    sb.push_back('{z: m.z, st: m.st, lat: m.sp ? LAT_SP : 28, acc: cyc});
  endtask
  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask
  function automatic logic [31:0] rand_fp();
    logic s;
    logic [7:0] ex;
    logic [22:0] fr;
    int c;
    s = 1'($urandom);
    fr = 23'($urandom);
    ex = 8'($urandom_range(100, 154));
    c = $urandom_range(0, 19);
    if (c == 0) begin ex = 8'd0; fr = 23'd0; end
    else if (c == 1) ex = 8'd0;
    else if (c == 2) begin ex = 8'hFF; fr = 23'd0; end
    else if (c == 3) begin ex = 8'hFF; fr = fr | 23'd1; end
    else if (c == 4) ex = 8'($urandom_range(240, 254));
    else if (c == 5) ex = 8'($urandom_range(1, 15));
    else if (c == 6) fr = fr & 23'h7F0000;
    return {s, ex, fr};
  endfunction
  // scoreboard compare on every cycle: result at done, busy while in flight, no stray done
  always @(negedge clk) begin
    ent_t x;
    if (!rst) begin
      if (done) begin
        if (sb.size() == 0) chk("spurious_done", {39'd0, done}, 40'd0);
        else begin
          x = sb.pop_front();
          chk("z", {8'd0, z}, {8'd0, x.z});
          chk("status", {32'd0, status}, {32'd0, x.st});
          chk("latency", 40'(cyc - int'(x.acc) + 1), {8'd0, x.lat});
          chk("busy_at_done", {39'd0, busy}, 40'd0);
        end
      end else if (sb.size() != 0) chk("busy_in_flight", {39'd0, busy}, 40'd1);
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1);
  end
  initial begin
    logic [31:0] ra, rb;
    int k;
    repeat (2) @(negedge clk);
    chk("rst_busy", {39'd0, busy}, 40'd0);
    chk("rst_done", {39'd0, done}, 40'd0);
    chk("rst_z", {8'd0, z}, 40'd0);
    chk("rst_status", {32'd0, status}, 40'd0);
    rst = 1'b0;
    @(negedge clk);
    pin("pin_3_div_2", 32'h40C00000, 32'h40000000, 3'd0, 40'h40400000_00);
    pin("pin_third_rne", 32'h3F800000, 32'h40400000, 3'd0, 40'h3EAAAAAB_20);
    pin("pin_third_rtz", 32'h3F800000, 32'h40400000, 3'd1, 40'h3EAAAAAA_20);
    pin("pin_third_rup", 32'h3F800000, 32'h40400000, 3'd2, 40'h3EAAAAAB_20);
    pin("pin_third_rna", 32'h3F800000, 32'h40400000, 3'd4, 40'h3EAAAAAB_20);
    pin("pin_negthird_rdn", 32'hBF800000, 32'h40400000, 3'd3, 40'hBEAAAAAB_20);
    pin("pin_negthird_rup", 32'hBF800000, 32'h40400000, 3'd2, 40'hBEAAAAAA_20);
    pin("pin_div_zero", 32'h3F800000, 32'h00000000, 3'd0, 40'h7F800000_42);
    pin("pin_zero_zero", 32'h00000000, 32'h00000000, 3'd0, 40'h7FC00000_04);
    pin("pin_ovf_rne", 32'h7F7FFFFF, 32'h00800000, 3'd0, 40'h7F800000_32);
    pin("pin_ovf_rtz", 32'h7F7FFFFF, 32'h00800000, 3'd1, 40'h7F7FFFFF_30);
    pin("pin_unf_rne", 32'h00800000, 32'h7F7FFFFF, 3'd0, 40'h00000000_29);
    pin("pin_unf_raw", 32'h00800000, 32'h7F7FFFFF, 3'd5, 40'h00800000_28);
    pin("pin_inf_fin", 32'h7F800000, 32'h40000000, 3'd0, 40'h7F800000_02);
    pin("pin_fin_inf", 32'hC0000000, 32'h7F800000, 3'd0, 40'h80000000_01);
    issue(32'h40C00000, 32'h40000000, 3'd0);
    issue(32'h3F800000, 32'h40400000, 3'd0);
    issue(32'h3F800000, 32'h40400000, 3'd1);
    issue(32'hBF800000, 32'h40400000, 3'd3);
    issue(32'h3F800000, 32'h00000000, 3'd0);
    issue(32'h00000000, 32'h00000000, 3'd0);
    issue(32'h7F7FFFFF, 32'h00800000, 3'd0);
    issue(32'h7F7FFFFF, 32'h00800000, 3'd1);
    issue(32'h00800000, 32'h7F7FFFFF, 3'd0);
    issue(32'h00800000, 32'h7F7FFFFF, 3'd5);
    issue(32'h7F800000, 32'h40000000, 3'd6);
    issue(32'hC0000000, 32'h7F800000, 3'd7);
    drain();
    issue(32'h3F800000, 32'h40400000, 3'd0);
    repeat (4) @(negedge clk);
    a = 32'hC1200000;
    b = 32'h3F000000;
    rnd = 3'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain();
    issue(32'h40C00000, 32'h40000000, 3'd0);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_busy", {39'd0, busy}, 40'd0);
    chk("midrst_done", {39'd0, done}, 40'd0);
    chk("midrst_z", {8'd0, z}, 40'd0);
    chk("midrst_status", {32'd0, status}, 40'd0);
    sb.delete();
    rst = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'h3F800000, 32'h40400000, 3'd1);
    drain();
    for (int i = 0; i < 250; i++) begin
      ra = rand_fp();
      rb = rand_fp();
      k = $urandom_range(0, 9);
      if (k == 0) begin
        ra[30:23] = 8'($urandom_range(200, 254));
        rb[30:23] = 8'($urandom_range(1, 60));
      end else if (k == 1) begin
        ra[30:23] = 8'($urandom_range(1, 60));
        rb[30:23] = 8'($urandom_range(200, 254));
      end else if (k == 2) begin
        rb[30:23] = 8'($urandom_range(1, 120));
        ra[30:23] = rb[30:23] + 8'($urandom_range(125, 130));
      end else if (k == 3) begin
        ra[30:23] = 8'($urandom_range(1, 120));
        rb[30:23] = ra[30:23] + 8'($urandom_range(124, 129));
      end
      issue(ra, rb, 3'($urandom_range(0, 7)));
    end
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/fp_div_seq.md
# fp_div_seq

Sequential IEEE-754 single-precision divider: z = a / b, computed one quotient bit per cycle by a restoring mantissa divider under a start/busy/done handshake. It is the inverse-operation companion to the combinational multiplier. It uses the same operand format, rounding-mode encoding and 8-bit status vector, so the two units sit side by side in the FP datapath.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in IDLE
- a  in  32  dividend, IEEE-754 single
- b  in  32  divisor, IEEE-754 single
- rnd  in  3  rounding mode, sampled with start: 000 near-even, 001 zero, 010 +inf, 011 -inf, 100 near-up, 101 away-from-zero (others = near-even)
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse; z/status valid from this cycle
- z  out  32  result, held until the next accepted start
- status  out  8  [0] zero, [1] inf, [2] nan, [3] tiny, [4] huge, [5] inexact, [6] div_by_zero, [7] 0

## Operation
- FSM states: IDLE, ITER, ROUND, DONE. IDLE -start-> ITER (normal) or ROUND (special, fast path). ITER -26 iterations-> ROUND -> DONE -> IDLE.
- At accept, a, b and rnd are captured. Denormal inputs are treated as signed zero. Sign = sa ^ sb.
- Exponent: e = ea - eb + 127, in 10-bit signed. If ma < mb (24-bit with hidden 1), ma is shifted left 1 and e is decremented, so the quotient lies in [1,2).
- ITER: restoring step per cycle: rem = rem - mb if rem >= mb, q bit = 1, then rem <<= 1. After 26 cycles: 1 integer bit, 23 fraction bits, guard bit, round bit. sticky = (rem != 0).
- ROUND: the rnd mode is applied to guard/round/sticky. A mantissa carry-out increments e.
  - e >= 255: huge + inexact. Result is ±inf (inf bit set) for modes that round away, otherwise ±max-normal 7F7FFFFF.
  - e <= 0: tiny + inexact. Result is ±min-normal for modes rounding away from zero, otherwise ±0 (zero bit set). No subnormal output.
- Special cases, in priority order:
  - Either operand NaN, 0/0 or inf/inf → 7FC00000, nan.
  - finite-nonzero/0 → ±inf, inf + div_by_zero.
  - inf/finite → ±inf, inf.
  - 0/nonzero or finite/inf → ±0, zero.
- start is ignored while busy or in DONE.

## Timing
- Reset: state IDLE, busy 0, done 0, z 32'h0, status 8'h0. Reset mid-operation aborts with no done pulse.
- start seen at edge 0:
  - Normal operands: busy high edges 0..27. ROUND executes at edge 27. done and z valid in the cycle after edge 27 (latency 28).
  - Special operands with the fast path compiled in: done after edge 1 (latency 2).
- done lasts exactly one cycle; busy is low while done is high. A new start is accepted in the cycle after done.

## Configuration
- FP_DIV_EARLY_EXIT_EN defined: special operands take the 2-cycle fast path.
- Undefined: special operands still traverse all 26 ITER cycles with the quotient discarded, giving a constant 28-cycle latency. Results and status are identical in both builds.

## Structure
- Shared package fp_pkg holds:
  - rounding-mode enum
  - status bit index constants
  - BIAS = 127
  - QNAN = 32'h7FC00000, INF = 32'h7F800000, MAX_NORM = 32'h7F7FFFFF
  - FSM state typedef
- Sub-module mant_div_seq: the 26-step restoring mantissa divider with load/step inputs, quotient output and sticky output. The top level holds unpacking, the FSM, special-case logic and rounding.

## Test plan
- 40C00000 / 40000000, rnd 000 → z 40400000, status 00, done exactly 28 cycles after start.
- 3F800000 / 40400000:
  - rnd 000 → 3EAAAAAB, status 20.
  - rnd 001 → 3EAAAAAA, status 20.
- 3F800000 / 00000000 → 7F800000, status 42. Done at 2 cycles with FP_DIV_EARLY_EXIT_EN, 28 without. 00000000/00000000 → 7FC00000, status 04.
- 7F7FFFFF / 00800000:
  - rnd 000 → 7F800000, status 32.
  - rnd 001 → 7F7FFFFF, status 30.
- 00800000 / 7F7FFFFF, rnd 000 → 00000000, status 29.
- Handshake and reset:
  - A second start at cycle 5 of a busy operation is ignored, and the first result is delivered unchanged.
  - rst asserted at cycle 10 → busy/done/z/status all 0 with no done pulse. The next start completes normally.
